// File: rtl/sram_arbiter.sv
// Two-port arbiter sharing one req/addr_ok/data_ok SRAM bus between instruction
// fetch and MEM-stage data access; data port wins, results held until the pipeline advances.
module sram_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    inst_en,
    input  logic [ADDR_WIDTH-1:0]   inst_addr,
    output logic [DATA_WIDTH-1:0]   inst_rdata,

    input  logic                    data_en,
    input  logic [DATA_WIDTH/8-1:0] data_wen,
    input  logic [ADDR_WIDTH-1:0]   data_addr,
    input  logic [DATA_WIDTH-1:0]   data_wdata,
    output logic [DATA_WIDTH-1:0]   data_rdata,

    output logic                    stall_req,

    output logic                    bus_req,
    output logic [DATA_WIDTH/8-1:0] bus_wen,
    output logic [ADDR_WIDTH-1:0]   bus_addr,
    output logic [DATA_WIDTH-1:0]   bus_wdata,
    input  logic                    bus_addr_ok,
    input  logic [DATA_WIDTH-1:0]   bus_rdata,
    input  logic                    bus_data_ok
);

    localparam int BE_W = DATA_WIDTH / 8;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] D_ADDR = 3'd1;
    localparam logic [2:0] D_WAIT = 3'd2;
    localparam logic [2:0] I_ADDR = 3'd3;
    localparam logic [2:0] I_WAIT = 3'd4;

    logic [2:0]            state_q,      state_d;
    logic                  bus_req_q,    bus_req_d;
    logic [BE_W-1:0]       bus_wen_q,    bus_wen_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q,   bus_addr_d;
    logic [DATA_WIDTH-1:0] bus_wdata_q,  bus_wdata_d;
    logic [DATA_WIDTH-1:0] inst_rdata_q, inst_rdata_d;
    logic [DATA_WIDTH-1:0] data_rdata_q, data_rdata_d;
    logic                  inst_done_q,  inst_done_d;
    logic                  data_done_q,  data_done_d;

    logic inst_pend;
    logic data_pend;

    assign inst_pend = inst_en & ~inst_done_q;
    assign data_pend = data_en & ~data_done_q;
    assign stall_req = inst_pend | data_pend;

    always_comb begin
        state_d      = state_q;
        bus_req_d    = bus_req_q;
        bus_wen_d    = bus_wen_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_done_d  = inst_done_q;
        data_done_d  = data_done_q;

        case (state_q)
            IDLE: begin
                // Ports are sampled only here, so the bus sees a stable latched request.
                if (data_pend) begin
                    state_d     = D_ADDR;
                    bus_req_d   = 1'b1;
                    bus_wen_d   = data_wen;
                    bus_addr_d  = data_addr;
                    bus_wdata_d = data_wdata;
                end else if (inst_pend) begin
                    state_d     = I_ADDR;
                    bus_req_d   = 1'b1;
                    bus_wen_d   = '0;
                    bus_addr_d  = inst_addr;
                    bus_wdata_d = '0;
                end
            end
            D_ADDR: begin
                if (bus_addr_ok) begin
                    state_d   = D_WAIT;
                    bus_req_d = 1'b0;
                end
            end
            I_ADDR: begin
                if (bus_addr_ok) begin
                    state_d   = I_WAIT;
                    bus_req_d = 1'b0;
                end
            end
            D_WAIT: begin
                if (bus_data_ok) begin
                    state_d      = IDLE;
                    data_rdata_d = bus_rdata;
                    data_done_d  = 1'b1;
                end
            end
            I_WAIT: begin
                if (bus_data_ok) begin
                    state_d      = IDLE;
                    inst_rdata_d = bus_rdata;
                    inst_done_d  = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
            end
        endcase

        // Pipeline advances on any cycle without a stall; completed results are consumed.
        if (!stall_req) begin
            inst_done_d = 1'b0;
            data_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            bus_req_q    <= 1'b0;
            bus_wen_q    <= '0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            inst_done_q  <= 1'b0;
            data_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bus_req_q    <= bus_req_d;
            bus_wen_q    <= bus_wen_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            inst_done_q  <= inst_done_d;
            data_done_q  <= data_done_d;
        end
    end

    assign bus_req    = bus_req_q;
    assign bus_wen    = bus_wen_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: hand-driven bus slave, hand-computed expectations.
module tb_sram_arbiter;

    logic        clk;
    logic        rst;
    logic        inst_en;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        data_en;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        stall_req;
    logic        bus_req;
    logic [3:0]  bus_wen;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic [31:0] bus_rdata;
    logic        bus_data_ok;

    int n_chk = 0;
    int n_err = 0;
    int n_acc = 0;

    sram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
        .data_en(data_en), .data_wen(data_wen), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata),
        .stall_req(stall_req),
        .bus_req(bus_req), .bus_wen(bus_wen), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
        .bus_rdata(bus_rdata), .bus_data_ok(bus_data_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Address handshakes accepted by the bus.
    always @(posedge clk) if (rst && bus_req && bus_addr_ok) n_acc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int acc0;

    initial begin
        rst = 1'b0; inst_en = 0; inst_addr = 0; data_en = 1; data_wen = 0;
        data_addr = 0; data_wdata = 0; bus_addr_ok = 0; bus_rdata = 0; bus_data_ok = 0;

        // Reset held two cycles with a pending data request
        step(); step();
        chk("rst bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst stall", {31'd0, stall_req}, 32'd1);
        chk("rst bus_addr", bus_addr, 32'd0);
        chk("rst bus_wdata", bus_wdata, 32'd0);
        chk("rst bus_wen", {28'd0, bus_wen}, 32'd0);
        chk("rst inst_rdata", inst_rdata, 32'd0);
        chk("rst data_rdata", data_rdata, 32'd0);
        data_en = 0;
        step();
        rst = 1'b1;

        // Single fetch: addr_ok at cycle 1, data_ok at cycle 3, stall drops at cycle 4
        inst_en = 1; inst_addr = 32'hBFC0_0000; #1;
        chk("fetch c0 stall", {31'd0, stall_req}, 32'd1);
        step();
        chk("fetch c1 bus_req", {31'd0, bus_req}, 32'd1);
        chk("fetch c1 bus_addr", bus_addr, 32'hBFC0_0000);
        chk("fetch c1 bus_wen", {28'd0, bus_wen}, 32'd0);
        bus_addr_ok = 1;
        step();
        bus_addr_ok = 0;
        chk("fetch c2 bus_req", {31'd0, bus_req}, 32'd0);
        chk("fetch c2 stall", {31'd0, stall_req}, 32'd1);
        step();
        chk("fetch c3 stall", {31'd0, stall_req}, 32'd1);
        bus_data_ok = 1; bus_rdata = 32'h3C08_BFC0;
        step();
        bus_data_ok = 0;
        chk("fetch c4 stall", {31'd0, stall_req}, 32'd0);
        chk("fetch c4 inst_rdata", inst_rdata, 32'h3C08_BFC0);
        inst_en = 0;
        step();

        // Concurrent write + fetch: write first
        inst_en = 1; inst_addr = 32'hBFC0_0004;
        data_en = 1; data_wen = 4'b0100; data_addr = 32'h8000_1000; data_wdata = 32'h00AB_0000;
        step();
        chk("conc d bus_req", {31'd0, bus_req}, 32'd1);
        chk("conc d bus_wen", {28'd0, bus_wen}, 32'h4);
        chk("conc d bus_addr", bus_addr, 32'h8000_1000);
        chk("conc d bus_wdata", bus_wdata, 32'h00AB_0000);
        bus_addr_ok = 1;
        step();
        bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h0;
        step();
        bus_data_ok = 0;
        chk("conc mid stall", {31'd0, stall_req}, 32'd1);
        chk("conc mid bus_req", {31'd0, bus_req}, 32'd0);
        step();
        chk("conc i bus_req", {31'd0, bus_req}, 32'd1);
        chk("conc i bus_addr", bus_addr, 32'hBFC0_0004);
        chk("conc i bus_wen", {28'd0, bus_wen}, 32'd0);
        bus_addr_ok = 1;
        step();
        bus_addr_ok = 0;
        chk("conc iwait stall", {31'd0, stall_req}, 32'd1);
        bus_data_ok = 1; bus_rdata = 32'h1122_3344;
        step();
        bus_data_ok = 0;
        chk("conc end stall", {31'd0, stall_req}, 32'd0);
        chk("conc inst_rdata", inst_rdata, 32'h1122_3344);
        inst_en = 0; data_en = 0;
        step();

        // Slave wait states on addr_ok; inputs wiggle mid-transaction
        acc0 = n_acc;
        data_en = 1; data_wen = 4'b0000; data_addr = 32'h8000_2000; data_wdata = 32'hDEAD_BEEF;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("wait bus_req", {31'd0, bus_req}, 32'd1);
            chk("wait bus_addr", bus_addr, 32'h8000_2000);
            chk("wait bus_wdata", bus_wdata, 32'hDEAD_BEEF);
            data_addr = 32'h8000_2F00 + i; data_wdata = 32'h1234_0000 + i;
            step();
        end
        chk("wait c4 bus_req", {31'd0, bus_req}, 32'd1);
        chk("wait c4 bus_addr", bus_addr, 32'h8000_2000);
        bus_addr_ok = 1;
        step();
        bus_addr_ok = 0;
        chk("wait c5 bus_req", {31'd0, bus_req}, 32'd0);
        bus_data_ok = 1; bus_rdata = 32'hCAFE_F00D;
        step();
        bus_data_ok = 0;
        chk("wait stall", {31'd0, stall_req}, 32'd0);
        chk("wait data_rdata", data_rdata, 32'hCAFE_F00D);
        data_en = 0;
        step(); step();
        chk("wait idle bus_req", {31'd0, bus_req}, 32'd0);
        chk("wait one txn", n_acc - acc0, 32'd1);

        // Reset while in D_WAIT; late data_ok must be ignored
        data_en = 1; data_wen = 0; data_addr = 32'h8000_3000;
        step();
        bus_addr_ok = 1;
        step();
        bus_addr_ok = 0; rst = 1'b0;
        step();
        rst = 1'b1; bus_data_ok = 1; bus_rdata = 32'h55AA_55AA;
        step();
        bus_data_ok = 0;
        chk("mrst data_rdata", data_rdata, 32'd0);
        chk("mrst stall", {31'd0, stall_req}, 32'd1);
        chk("mrst reissue", {31'd0, bus_req}, 32'd1);
        chk("mrst bus_addr", bus_addr, 32'h8000_3000);
        bus_addr_ok = 1;
        step();
        bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h0000_7777;
        step();
        bus_data_ok = 0;
        chk("mrst done rdata", data_rdata, 32'h0000_7777);
        data_en = 0;
        step();

        // Load completes, fetch finishes later; load data held until pipeline advances
        inst_en = 1; inst_addr = 32'hBFC0_0100;
        data_en = 1; data_wen = 0; data_addr = 32'h8000_4000;
        step();
        bus_addr_ok = 1;
        step();
        bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'hA5A5_0001;
        step();
        bus_data_ok = 0;
        chk("hold c3 data_rdata", data_rdata, 32'hA5A5_0001);
        chk("hold c3 stall", {31'd0, stall_req}, 32'd1);
        step();
        chk("hold c4 bus_addr", bus_addr, 32'hBFC0_0100);
        chk("hold c4 data_rdata", data_rdata, 32'hA5A5_0001);
        step();
        bus_addr_ok = 1;
        step();
        bus_addr_ok = 0;
        step();
        chk("hold c7 data_rdata", data_rdata, 32'hA5A5_0001);
        chk("hold c7 stall", {31'd0, stall_req}, 32'd1);
        bus_data_ok = 1; bus_rdata = 32'h0BAD_0BAD;
        step();
        bus_data_ok = 0;
        chk("hold c8 stall", {31'd0, stall_req}, 32'd0);
        chk("hold c8 data_rdata", data_rdata, 32'hA5A5_0001);
        chk("hold c8 inst_rdata", inst_rdata, 32'h0BAD_0BAD);
        step();
        chk("hold done cleared", {31'd0, stall_req}, 32'd1);
        inst_en = 0; data_en = 0;
        step(); step();
        chk("final bus_req", {31'd0, bus_req}, 32'd0);
        chk("total txns", n_acc, 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
